// File: rtl/commit_stage_reg_pkg.sv
// Shared definitions for the MEM->WB commit register and its squash helper.
// Lane 0 is always the oldest instruction of an issue group.
package commit_pkg;

  localparam int LANE_OLDEST = 0;
  localparam int MAX_LANES   = 32;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Keep mask: a lane survives unless an older valid lane is excepting.
  function automatic logic [MAX_LANES-1:0] squash_mask(
    input logic [MAX_LANES-1:0] valid,
    input logic [MAX_LANES-1:0] except
  );
    logic hit;
    squash_mask = '0;
    hit         = 1'b0;
    for (int i = LANE_OLDEST; i < MAX_LANES; i++) begin
      squash_mask[i] = ~hit;
      hit            = hit | (valid[i] & except[i]);
    end
  endfunction

endpackage

// File: rtl/commit_stage_reg_younger_squash.sv
// Combinational keep mask: priority scan from the oldest lane, dropping every
// lane younger than the first valid excepting lane (that lane itself is kept).
module younger_squash
  import commit_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0] i_valid,
  input  logic [LANES-1:0] i_except,
  output logic [LANES-1:0] o_keep
);

  always_comb begin
    logic w_hit;
    w_hit  = 1'b0;
    o_keep = '0;
    for (int i = LANE_OLDEST; i < LANES; i++) begin
      o_keep[i] = ~w_hit;
      w_hit     = w_hit | (i_valid[i] & i_except[i]);
    end
  end

endmodule

// File: rtl/commit_stage_reg.sv
// MEM->WB pipeline register: valid/ready handshake with a main+skid pair,
// younger-lane squash on write and zeroed storage for dead lanes.
module commit_stage_reg
  import commit_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 160
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES-1:0]           in_except,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload,
  output logic                       in_ready,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES-1:0]           out_except,
  output logic [LANES*PAYLOAD_W-1:0] out_payload,
  input  logic                       out_ready,
  output occ_t                       occupancy
);

  occ_t                              r_occ;
  logic [LANES-1:0]                  r_main_valid, r_main_exc;
  logic [LANES-1:0]                  r_skid_valid, r_skid_exc;
  logic [LANES-1:0][PAYLOAD_W-1:0]   r_main_pay, r_skid_pay;

  logic [LANES-1:0]                  w_keep, w_wr_valid, w_wr_exc;
  logic [LANES-1:0][PAYLOAD_W-1:0]   w_wr_pay;
  logic                              w_push, w_pop;

  younger_squash #(.LANES(LANES)) u_squash (
    .i_valid  (in_valid),
    .i_except (in_except),
    .o_keep   (w_keep)
  );

  // Dead lanes (invalid or squashed) are written as all-zero.
  assign w_wr_valid = in_valid & w_keep;
  assign w_wr_exc   = in_except & w_wr_valid;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_wr_pay[g] = w_wr_valid[g] ? in_payload[g*PAYLOAD_W +: PAYLOAD_W] : '0;
    assign out_payload[g*PAYLOAD_W +: PAYLOAD_W] = r_main_pay[g];
  end

  // in_ready comes only from the occupancy flops, never from out_ready.
  assign in_ready   = (r_occ != OCC_FULL);
  assign out_valid  = r_main_valid;
  assign out_except = r_main_exc;
  assign occupancy  = r_occ;

  assign w_push = in_ready & (|in_valid);
  assign w_pop  = out_ready & (|r_main_valid);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ        <= OCC_EMPTY;
      r_main_valid <= '0;
      r_main_exc   <= '0;
      r_main_pay   <= '0;
      r_skid_valid <= '0;
      r_skid_exc   <= '0;
      r_skid_pay   <= '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            r_main_valid <= w_wr_valid;
            r_main_exc   <= w_wr_exc;
            r_main_pay   <= w_wr_pay;
            r_occ        <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_main_valid <= w_wr_valid;
            r_main_exc   <= w_wr_exc;
            r_main_pay   <= w_wr_pay;
          end else if (w_push) begin
            r_skid_valid <= w_wr_valid;
            r_skid_exc   <= w_wr_exc;
            r_skid_pay   <= w_wr_pay;
            r_occ        <= OCC_FULL;
          end else if (w_pop) begin
            r_main_valid <= '0;
            r_main_exc   <= '0;
            r_main_pay   <= '0;
            r_occ        <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_pop) begin
            r_main_valid <= r_skid_valid;
            r_main_exc   <= r_skid_exc;
            r_main_pay   <= r_skid_pay;
            r_skid_valid <= '0;
            r_skid_exc   <= '0;
            r_skid_pay   <= '0;
            r_occ        <= OCC_ONE;
          end
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

endmodule
